systolic_ws_feeder: RTL

- Edge controller that drives a ROWS x COLS weight-stationary PE array.
- Buffers one weight tile from a valid/ready stream, then issues it top-down using the PE cell_sc_en capture chain.
- Streams activation vectors into the left edge with per-row diagonal skew, generates pipeline_en and reg_clear, and signals completion.
- Counterpart of the PE: produces everything the PE consumes at the array boundary.

---
 rtl/systolic_feeder_pkg.sv | 39 +++
 rtl/systolic_ws_feeder_skew.sv | 45 ++++
 rtl/systolic_ws_feeder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the weight-stationary array feeder: FSM encoding,
// phase-length formulas and a constant clog2 helper.
package systolic_feeder_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_CLEAR    = 3'd1;
   localparam logic [2:0] ST_LOAD_BUF = 3'd2;
   localparam logic [2:0] ST_ISSUE    = 3'd3;
   localparam logic [2:0] ST_SETTLE   = 3'd4;
   localparam logic [2:0] ST_STREAM   = 3'd5;
   localparam logic [2:0] ST_DRAIN    = 3'd6;
   localparam logic [2:0] ST_DONE     = 3'd7;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

   // sc_en moves down the array two cycles per row, so the last row captures
   // 2*ROWS cycles after the first issue cycle at the latest.
   function automatic int settle_cyc(input int rows);
      return 2 * rows;
   endfunction

   // Last vector must ripple through the skew, across the columns and
   // through every PE pipeline stage before the array is quiet.
   function automatic int drain_cyc(input int rows, input int cols, input int stage);
      return (rows - 1) + (cols - 1) + rows * (stage + 1) + 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/systolic_ws_feeder_skew.sv
// Triangular activation delay line: lane r is delayed by r enabled cycles,
// lane 0 passes straight through.
module act_skew_line
   import systolic_feeder_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int WIDTH_A = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    shift,
   input  logic [ROWS*WIDTH_A-1:0] din,
   output logic [ROWS*WIDTH_A-1:0] dout
);

   assign dout[0 +: WIDTH_A] = din[0 +: WIDTH_A];

   genvar gi;
   generate
      for (gi = 1; gi < ROWS; gi++) begin : g_lane
         logic [WIDTH_A-1:0] stage_reg [gi];

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < gi; s++) begin
                  stage_reg[s] <= '0;
               end
            end else if (clear) begin
               for (int s = 0; s < gi; s++) begin
                  stage_reg[s] <= '0;
               end
            end else if (shift) begin
               stage_reg[0] <= din[gi*WIDTH_A +: WIDTH_A];
               for (int s = 1; s < gi; s++) begin
                  stage_reg[s] <= stage_reg[s-1];
               end
            end
         end

         assign dout[gi*WIDTH_A +: WIDTH_A] = stage_reg[gi-1];
      end
   endgenerate

endmodule

// File: rtl/systolic_ws_feeder.sv
// Edge controller for a ROWS x COLS weight-stationary PE array: buffers a
// weight tile, issues it down the sc_en chain, then streams skewed activations.
module systolic_ws_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int ROWS    = 4,
   parameter int COLS    = 4,
   parameter int WIDTH_A = 16,
   parameter int WIDTH_B = 16,
   parameter int STAGE   = 0,
   parameter int CNT_W   = 16
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        num_vec,
   input  logic [COLS*WIDTH_B-1:0] wei_in,
   input  logic                    wei_valid,
   output logic                    wei_ready,
   input  logic [ROWS*WIDTH_A-1:0] act_in,
   input  logic                    act_valid,
   output logic                    act_ready,
   output logic [COLS*WIDTH_B-1:0] arr_wei,
   output logic                    arr_cell_sc_en,
   output logic [ROWS*WIDTH_A-1:0] arr_act,
   output logic                    arr_pipeline_en,
   output logic                    arr_reg_clear,
   output logic                    busy,
   output logic                    done
);

   localparam int SETTLE_CYC = settle_cyc(ROWS);
   localparam int DRAIN_CYC  = drain_cyc(ROWS, COLS, STAGE);
   localparam int PH_MAX     = max_int(SETTLE_CYC, DRAIN_CYC);
   localparam int PH_W       = clog2(PH_MAX + 1);
   localparam int ROW_W      = clog2(ROWS + 1);
   localparam int IDX_W      = (ROWS > 1) ? clog2(ROWS) : 1;

   logic [2:0]             state_reg;
   logic [2:0]             state_next;
   logic [ROW_W-1:0]       row_cnt_reg;
   logic [PH_W-1:0]        phase_reg;
   logic [CNT_W-1:0]       vec_cnt_reg;
   logic [COLS*WIDTH_B-1:0] buffer_reg [ROWS];

   logic                   wei_acc;
   logic                   act_acc;
   logic                   phase_last;
   logic                   phase_run;
   logic                   skew_clear;
   logic                   skew_shift;
   logic [ROWS*WIDTH_A-1:0] skew_din;
   logic [ROWS*WIDTH_A-1:0] skew_out;

   assign wei_acc = wei_valid && (state_reg == ST_LOAD_BUF);
   assign act_acc = act_valid && (state_reg == ST_STREAM);

   always_comb begin
      phase_last = 1'b0;
      phase_run  = 1'b0;
      case (state_reg)
         ST_ISSUE: begin
            phase_run  = 1'b1;
            phase_last = (phase_reg == PH_W'(ROWS - 1));
         end
         ST_SETTLE: begin
            phase_run  = 1'b1;
            phase_last = (phase_reg == PH_W'(SETTLE_CYC - 1));
         end
         ST_DRAIN: begin
            phase_run  = 1'b1;
            phase_last = (phase_reg == PH_W'(DRAIN_CYC - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) state_next = ST_CLEAR;
         end
         ST_CLEAR: begin
            state_next = ST_LOAD_BUF;
         end
         ST_LOAD_BUF: begin
            if (wei_acc && (row_cnt_reg == ROW_W'(ROWS - 1))) state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (phase_last) state_next = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (phase_last) state_next = (vec_cnt_reg != '0) ? ST_STREAM : ST_DONE;
         end
         ST_STREAM: begin
            if (act_acc && (vec_cnt_reg == CNT_W'(1))) state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (phase_last) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wei_ready       = (state_reg == ST_LOAD_BUF);
      act_ready       = (state_reg == ST_STREAM);
      arr_cell_sc_en  = (state_reg == ST_ISSUE) || (state_reg == ST_SETTLE);
      arr_reg_clear   = (state_reg == ST_CLEAR);
      busy            = (state_reg != ST_IDLE);
      done            = (state_reg == ST_DONE);
      arr_pipeline_en = 1'b0;
      arr_wei         = '0;
      arr_act         = '0;
      case (state_reg)
         ST_ISSUE:  arr_wei = buffer_reg[phase_reg[IDX_W-1:0]];
         ST_SETTLE: arr_wei = buffer_reg[ROWS-1];
         ST_STREAM: begin
            arr_pipeline_en = act_valid;
            arr_act         = skew_out;
         end
         ST_DRAIN: begin
            arr_pipeline_en = 1'b1;
            arr_act         = skew_out;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_cnt_reg <= '0;
         phase_reg   <= '0;
         vec_cnt_reg <= '0;
      end else begin
         if ((state_reg == ST_IDLE) && start) begin
            vec_cnt_reg <= num_vec;
         end else if (act_acc && (vec_cnt_reg != '0)) begin
            vec_cnt_reg <= vec_cnt_reg - CNT_W'(1);
         end

         if (state_reg == ST_CLEAR) begin
            row_cnt_reg <= '0;
         end else if (wei_acc) begin
            row_cnt_reg <= row_cnt_reg + ROW_W'(1);
         end

         // Cleared between phases so each timed state starts counting at 0.
         if (phase_run && !phase_last) begin
            phase_reg <= phase_reg + PH_W'(1);
         end else begin
            phase_reg <= '0;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_buf
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               buffer_reg[gi] <= '0;
            end else if (wei_acc && (row_cnt_reg == ROW_W'(gi))) begin
               buffer_reg[gi] <= wei_in;
            end
         end
      end
   endgenerate

   assign skew_clear = (state_reg == ST_CLEAR);
   assign skew_shift = arr_pipeline_en;
   assign skew_din   = act_acc ? act_in : '0;

   act_skew_line #(
      .ROWS    (ROWS),
      .WIDTH_A (WIDTH_A)
   ) u_skew (
      .clk   (clk),
      .rst   (rst),
      .clear (skew_clear),
      .shift (skew_shift),
      .din   (skew_din),
      .dout  (skew_out)
   );

endmodule
